// File: rtl/dual_issue_queue.sv
// dual_issue_queue
//   Instruction queue between fetch and a dual-issue decode stage. Fetch
//   pushes one or two words per cycle. Each cycle up to two instructions
//   leave the queue in program order through the registered issue slots.
//   Slot 2 is used only when the head pair can be issued together.
//   Otherwise the younger word stays at the head for the next cycle.
//
// Ports
//   clk         in   1         rising-edge clock
//   rst         in   1         asynchronous, active-low reset
//   in_valid    in   1         fetch presents in_instr1 (and in_instr2 if in_valid2)
//   in_valid2   in   1         second fetched word valid; ignored unless in_valid
//   in_instr1   in   DATA_W    older fetched word
//   in_instr2   in   DATA_W    younger fetched word
//   in_ready    out  1         at least two free entries (combinational from count)
//   flush       in   1         synchronous discard of queue and issue registers
//   dec_stall   in   1         decode cannot accept: hold issue registers, no pop
//   out_valid1  out  1         out_instr1 valid
//   out_valid2  out  1         out_instr2 valid (only together with out_valid1)
//   out_instr1  out  DATA_W    issued older instruction
//   out_instr2  out  DATA_W    issued younger instruction
//   count       out  PTR_W+1   occupied entries
module dual_issue_queue #(
   parameter int DEPTH  = 8,
   parameter int PTR_W  = 3,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_valid2,
   input  logic [DATA_W-1:0] in_instr1,
   input  logic [DATA_W-1:0] in_instr2,
   output logic              in_ready,
   input  logic              flush,
   input  logic              dec_stall,
   output logic              out_valid1,
   output logic              out_valid2,
   output logic [DATA_W-1:0] out_instr1,
   output logic [DATA_W-1:0] out_instr2,
   output logic [PTR_W:0]    count
);

   localparam logic [PTR_W-1:0] P_ZERO    = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] P_ONE     = PTR_W'(1);
   localparam logic [PTR_W-1:0] P_TWO     = PTR_W'(2);
   localparam logic [PTR_W:0]   C_ZERO    = {(PTR_W+1){1'b0}};
   localparam logic [PTR_W:0]   C_ONE     = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   READY_MAX = (PTR_W+1)'(DEPTH-2);

   // Destination register written by an instruction; 0 means none.
   function automatic logic [4:0] dest_of(input logic [DATA_W-1:0] w);
      logic [5:0] op;
      logic [5:0] funct;
      logic [4:0] d;
      op    = w[31:26];
      funct = w[5:0];
      case (op)
         6'h00:   d = (funct == 6'h08) ? 5'd0 : w[15:11];
         6'h08, 6'h0c, 6'h0d, 6'h16, 6'h0a, 6'h23:
                  d = w[20:16];
         6'h03:   d = 5'd31;
         default: d = 5'd0;
      endcase
      return d;
   endfunction

   // Branches, jumps and jr must issue alone in slot 1.
   function automatic logic is_ctrl(input logic [DATA_W-1:0] w);
      logic [5:0] op;
      logic       r;
      op = w[31:26];
      case (op)
         6'h02, 6'h03, 6'h04, 6'h05: r = 1'b1;
         6'h00:                      r = (w[5:0] == 6'h08);
         default:                    r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_mem(input logic [DATA_W-1:0] w);
      return (w[31:26] == 6'h23) || (w[31:26] == 6'h2b);
   endfunction

   // True when A (older) and B (younger) may issue in the same cycle.
   function automatic logic pair_ok(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
      logic [4:0] da;
      logic       b_is_j;
      logic       raw;
      logic       waw;
      da     = dest_of(a);
      b_is_j = (b[31:26] == 6'h02) || (b[31:26] == 6'h03);
      // rs/rt of B are compared whatever its format; j/jal carry a target there.
      raw    = (da != 5'd0) && !b_is_j && ((da == b[25:21]) || (da == b[20:16]));
      waw    = (da != 5'd0) && (da == dest_of(b));
      return !is_ctrl(a) && !(is_mem(a) && is_mem(b)) && !raw && !waw;
   endfunction

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W:0]    count_r;

   logic              push_s;
   logic              issue_s;
   logic              pair_ok_s;
   logic [PTR_W-1:0]  push_inc_s;
   logic [PTR_W-1:0]  pop_inc_s;
   logic [DATA_W-1:0] head_a_s;
   logic [DATA_W-1:0] head_b_s;

   assign count    = count_r;
   assign in_ready = (count_r <= READY_MAX);
   assign head_a_s = mem_r[rd_ptr_r];
   assign head_b_s = mem_r[rd_ptr_r + P_ONE];

   // Push/pop decisions for this cycle.
   always_comb begin
      push_s     = in_valid && in_ready && !flush;
      issue_s    = !dec_stall && !flush;
      pair_ok_s  = pair_ok(head_a_s, head_b_s);
      push_inc_s = P_ZERO;
      pop_inc_s  = P_ZERO;
      if (push_s) begin
         push_inc_s = in_valid2 ? P_TWO : P_ONE;
      end else begin
         push_inc_s = P_ZERO;
      end
      if (!issue_s || count_r == C_ZERO) begin
         pop_inc_s = P_ZERO;
      end else if (count_r == C_ONE) begin
         pop_inc_s = P_ONE;
      end else begin
         pop_inc_s = pair_ok_s ? P_TWO : P_ONE;
      end
   end

   // Queue storage; contents are qualified by the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= in_instr1;
         if (in_valid2) begin
            mem_r[wr_ptr_r + P_ONE] <= in_instr2;
         end
      end
   end

   // Pointers, occupancy and the issue registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r   <= P_ZERO;
         rd_ptr_r   <= P_ZERO;
         count_r    <= C_ZERO;
         out_valid1 <= 1'b0;
         out_valid2 <= 1'b0;
         out_instr1 <= {DATA_W{1'b0}};
         out_instr2 <= {DATA_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r   <= P_ZERO;
         rd_ptr_r   <= P_ZERO;
         count_r    <= C_ZERO;
         out_valid1 <= 1'b0;
         out_valid2 <= 1'b0;
      end else begin
         wr_ptr_r <= wr_ptr_r + push_inc_s;
         rd_ptr_r <= rd_ptr_r + pop_inc_s;
         count_r  <= count_r + {1'b0, push_inc_s} - {1'b0, pop_inc_s};
         if (issue_s) begin
            if (count_r == C_ZERO) begin
               out_valid1 <= 1'b0;
               out_valid2 <= 1'b0;
            end else begin
               out_valid1 <= 1'b1;
               out_instr1 <= head_a_s;
               if (count_r != C_ONE && pair_ok_s) begin
                  out_valid2 <= 1'b1;
                  out_instr2 <= head_b_s;
               end else begin
                  out_valid2 <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dual_issue_queue.sv
module tb_dual_issue_queue;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_valid2;
   logic [31:0] in_instr1;
   logic [31:0] in_instr2;
   logic        in_ready;
   logic        flush;
   logic        dec_stall;
   logic        out_valid1;
   logic        out_valid2;
   logic [31:0] out_instr1;
   logic [31:0] out_instr2;
   logic [3:0]  count;

   int errors = 0;
   int checks = 0;

   dual_issue_queue #(.DEPTH(8), .PTR_W(3), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_valid2(in_valid2),
      .in_instr1(in_instr1), .in_instr2(in_instr2), .in_ready(in_ready),
      .flush(flush), .dec_stall(dec_stall), .out_valid1(out_valid1),
      .out_valid2(out_valid2), .out_instr1(out_instr1), .out_instr2(out_instr2),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic        iv2;
      logic [31:0] i1;
      logic [31:0] i2;
      logic        fl;
      logic        st;
      logic        ev1;
      logic        ev2;
      logic [31:0] eo1;
      logic [31:0] eo2;
      logic [3:0]  ecnt;
      logic        erdy;
   } vec_t;

   vec_t tbl[$];

   localparam logic [31:0] ADD1  = 32'h00221820; // add $3,$1,$2
   localparam logic [31:0] ADD2  = 32'h00853020; // add $6,$4,$5
   localparam logic [31:0] ADDI  = 32'h20640001; // addi $4,$3,1
   localparam logic [31:0] LW    = 32'h8C220000;
   localparam logic [31:0] SW    = 32'hAC240004;
   localparam logic [31:0] BEQ   = 32'h10220003;
   localparam logic [31:0] ADDW  = 32'h00A41820; // add $3,$5,$4 (WAW with ADD1)
   localparam logic [31:0] ADDI2 = 32'h20020005; // addi $2,$0,5
   localparam logic [31:0] JMP   = 32'h08020000; // j with rt-field bits == 2

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic iv2, input logic [31:0] i1,
                      input logic [31:0] i2, input logic fl, input logic st,
                      input logic ev1, input logic ev2, input logic [31:0] eo1,
                      input logic [31:0] eo2, input logic [3:0] ecnt, input logic erdy);
      vec_t v;
      v.iv = iv; v.iv2 = iv2; v.i1 = i1; v.i2 = i2; v.fl = fl; v.st = st;
      v.ev1 = ev1; v.ev2 = ev2; v.eo1 = eo1; v.eo2 = eo2; v.ecnt = ecnt; v.erdy = erdy;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic iv, input logic iv2, input logic [31:0] i1,
                        input logic [31:0] i2, input logic fl, input logic st);
      in_valid = iv; in_valid2 = iv2; in_instr1 = i1; in_instr2 = i2;
      flush = fl; dec_stall = st;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] wv(input int i);
      return 32'hFC000010 + 32'(i);
   endfunction

   logic [31:0] got[$];

   initial begin
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #12;
      chk("rst_v1", {31'h0, out_valid1}, 32'h0);
      chk("rst_v2", {31'h0, out_valid2}, 32'h0);
      chk("rst_o1", out_instr1, 32'h0);
      chk("rst_o2", out_instr2, 32'h0);
      chk("rst_cnt", {28'h0, count}, 32'h0);
      chk("rst_rdy", {31'h0, in_ready}, 32'h1);
      @(negedge clk);
      rst = 1'b1;

      //   iv    iv2   i1     i2    fl    st     ev1   ev2   eo1    eo2    cnt   rdy
      add(1'b1, 1'b1, ADD1,  ADD2, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0, 32'h0, 4'd2, 1'b1);
      add(1'b0, 1'b0, 32'h0, 32'h0,1'b0, 1'b0,  1'b1, 1'b1, ADD1,  ADD2,  4'd0, 1'b1);
      add(1'b1, 1'b1, ADD1,  ADDI, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0, 32'h0, 4'd2, 1'b1);
      add(1'b0, 1'b0, 32'h0, 32'h0,1'b0, 1'b0,  1'b1, 1'b0, ADD1,  32'h0, 4'd1, 1'b1);
      add(1'b0, 1'b0, 32'h0, 32'h0,1'b0, 1'b0,  1'b1, 1'b0, ADDI,  32'h0, 4'd0, 1'b1);
      add(1'b1, 1'b1, LW,    SW,   1'b0, 1'b0,  1'b0, 1'b0, 32'h0, 32'h0, 4'd2, 1'b1);
      add(1'b0, 1'b0, 32'h0, 32'h0,1'b0, 1'b0,  1'b1, 1'b0, LW,    32'h0, 4'd1, 1'b1);
      add(1'b1, 1'b1, BEQ,   ADD1, 1'b0, 1'b0,  1'b1, 1'b0, SW,    32'h0, 4'd2, 1'b1);
      add(1'b0, 1'b0, 32'h0, 32'h0,1'b0, 1'b0,  1'b1, 1'b0, BEQ,   32'h0, 4'd1, 1'b1);
      add(1'b0, 1'b0, 32'h0, 32'h0,1'b0, 1'b0,  1'b1, 1'b0, ADD1,  32'h0, 4'd0, 1'b1);
      add(1'b0, 1'b1, ADD2,  ADD2, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
      add(1'b1, 1'b0, ADD2,  ADD1, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0, 32'h0, 4'd1, 1'b1);
      add(1'b0, 1'b0, 32'h0, 32'h0,1'b0, 1'b0,  1'b1, 1'b0, ADD2,  32'h0, 4'd0, 1'b1);
      add(1'b1, 1'b1, ADD1,  ADD2, 1'b0, 1'b1,  1'b1, 1'b0, ADD2,  32'h0, 4'd2, 1'b1);
      add(1'b0, 1'b0, 32'h0, 32'h0,1'b0, 1'b0,  1'b1, 1'b1, ADD1,  ADD2,  4'd0, 1'b1);
      add(1'b1, 1'b1, ADD1,  ADDW, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0, 32'h0, 4'd2, 1'b1);
      add(1'b0, 1'b0, 32'h0, 32'h0,1'b0, 1'b0,  1'b1, 1'b0, ADD1,  32'h0, 4'd1, 1'b1);
      add(1'b0, 1'b0, 32'h0, 32'h0,1'b0, 1'b0,  1'b1, 1'b0, ADDW,  32'h0, 4'd0, 1'b1);
      add(1'b1, 1'b1, ADDI2, JMP,  1'b0, 1'b0,  1'b0, 1'b0, 32'h0, 32'h0, 4'd2, 1'b1);
      add(1'b0, 1'b0, 32'h0, 32'h0,1'b0, 1'b0,  1'b1, 1'b1, ADDI2, JMP,   4'd0, 1'b1);
      add(1'b0, 1'b0, 32'h0, 32'h0,1'b0, 1'b0,  1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].iv, tbl[i].iv2, tbl[i].i1, tbl[i].i2, tbl[i].fl, tbl[i].st);
         step();
         chk($sformatf("row%0d_v1", i), {31'h0, out_valid1}, {31'h0, tbl[i].ev1});
         chk($sformatf("row%0d_v2", i), {31'h0, out_valid2}, {31'h0, tbl[i].ev2});
         if (tbl[i].ev1) chk($sformatf("row%0d_o1", i), out_instr1, tbl[i].eo1);
         if (tbl[i].ev2) chk($sformatf("row%0d_o2", i), out_instr2, tbl[i].eo2);
         chk($sformatf("row%0d_cnt", i), {28'h0, count}, {28'h0, tbl[i].ecnt});
         chk($sformatf("row%0d_rdy", i), {31'h0, in_ready}, {31'h0, tbl[i].erdy});
      end

      // Fill under stall up to the full threshold, then drain across the wrap.
      for (int p = 0; p < 3; p++) begin
         drive(1'b1, 1'b1, wv(2*p), wv(2*p+1), 1'b0, 1'b1);
         step();
         chk($sformatf("fill%0d_cnt", p), {28'h0, count}, 32'(2*p+2));
         chk($sformatf("fill%0d_rdy", p), {31'h0, in_ready}, 32'h1);
      end
      drive(1'b1, 1'b0, wv(6), 32'h0, 1'b0, 1'b1);
      step();
      chk("fill7_cnt", {28'h0, count}, 32'd7);
      chk("fill7_rdy", {31'h0, in_ready}, 32'h0);
      drive(1'b1, 1'b1, wv(7), wv(8), 1'b0, 1'b1);
      step();
      chk("held_cnt", {28'h0, count}, 32'd7);
      chk("held_rdy", {31'h0, in_ready}, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int c = 0; c < 6; c++) begin
         step();
         chk($sformatf("drain%0d_v2_needs_v1", c), {31'h0, out_valid2 & ~out_valid1}, 32'h0);
         if (out_valid1) got.push_back(out_instr1);
         if (out_valid2) got.push_back(out_instr2);
      end
      chk("drain_len", 32'(got.size()), 32'd7);
      for (int k = 0; k < 7; k++) begin
         if (k < got.size()) chk($sformatf("drain_w%0d", k), got[k], wv(k));
      end
      chk("drain_cnt", {28'h0, count}, 32'h0);

      // Flush at count 5 with a simultaneous push.
      drive(1'b1, 1'b1, ADD1, ADD2, 1'b0, 1'b1);
      step();
      drive(1'b1, 1'b1, ADD1, ADD2, 1'b0, 1'b1);
      step();
      drive(1'b1, 1'b0, ADD1, 32'h0, 1'b0, 1'b1);
      step();
      chk("pre_flush_cnt", {28'h0, count}, 32'd5);
      drive(1'b1, 1'b1, ADD1, ADD2, 1'b1, 1'b0);
      step();
      chk("flush_cnt", {28'h0, count}, 32'h0);
      chk("flush_v1", {31'h0, out_valid1}, 32'h0);
      chk("flush_v2", {31'h0, out_valid2}, 32'h0);
      chk("flush_rdy", {31'h0, in_ready}, 32'h1);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      chk("post_flush_v1", {31'h0, out_valid1}, 32'h0);
      chk("post_flush_cnt", {28'h0, count}, 32'h0);

      // Asynchronous reset in the middle of a drain.
      for (int p = 0; p < 3; p++) begin
         drive(1'b1, 1'b1, wv(2*p), wv(2*p+1), 1'b0, 1'b1);
         step();
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      chk("mid_v1", {31'h0, out_valid1}, 32'h1);
      chk("mid_cnt", {28'h0, count}, 32'd4);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_v1", {31'h0, out_valid1}, 32'h0);
      chk("arst_v2", {31'h0, out_valid2}, 32'h0);
      chk("arst_o1", out_instr1, 32'h0);
      chk("arst_o2", out_instr2, 32'h0);
      chk("arst_cnt", {28'h0, count}, 32'h0);
      chk("arst_rdy", {31'h0, in_ready}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 1'b1, ADD1, ADD2, 1'b0, 1'b0);
      step();
      chk("post_rst_cnt", {28'h0, count}, 32'd2);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      chk("post_rst_v1", {31'h0, out_valid1}, 32'h1);
      chk("post_rst_v2", {31'h0, out_valid2}, 32'h1);
      chk("post_rst_o1", out_instr1, ADD1);
      chk("post_rst_o2", out_instr2, ADD2);
      chk("post_rst_cnt0", {28'h0, count}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
